block_ram_dual_port_pipelined: RTL and testbench
================================================

// Module: block_ram_dual_port_pipelined
// PURPOSE
//  True dual-port block RAM with per-byte write enables, selectable read latency (1 or 2) and per-port
//  read-valid tracking. Same-port read-during-write mode and deterministic cross-port collision rules.
//  Successor to the plain dual-port RAM. Used for feature-map and weight buffers in the accelerator
//  datapath, where consumers need a valid strobe and a registered output for timing closure.
// PARAMETERS
//  DATA_WIDTH    32             word width; must be a multiple of BYTE_WIDTH
//  BYTE_WIDTH    8              width of one write-enable lane; NUM_LANES = DATA_WIDTH/BYTE_WIDTH
//  DEPTH         2**16          number of words; AW = $clog2(DEPTH)
//  READ_LATENCY  1              1 = array read register only; 2 = extra output register
//  RD_MODE       "READ_FIRST"   same-port read+write to one address: "READ_FIRST" | "WRITE_FIRST"
//  RAM_STYLE     "auto"         synthesis ram_style attribute on the array
// PORTS
//  clk           in   1           clock, all logic on posedge
//  rst           in   1           asynchronous, active-high reset
//  addr_a/b      in   AW          port A/B word address
//  wr_data_a/b   in   DATA_WIDTH  write data
//  wr_be_a/b     in   NUM_LANES   byte-lane write enable; lane i covers bits [i*BYTE_WIDTH +: BYTE_WIDTH]
//  wr_en_a/b     in   1           write strobe; a lane is written only if wr_en & wr_be[i]
//  rd_en_a/b     in   1           read strobe
//  rd_data_a/b   out  DATA_WIDTH  read data, valid when rd_valid_x=1
//  rd_valid_a/b  out  1           1-cycle pulse, READ_LATENCY cycles after the rd_en cycle
//  collision     out  1           only with BRAM_COLLISION_DETECT_EN (see CONFIGURATION)
// BEHAVIOUR
//  - Reset (async assert, sync-released by the parent): rd_data_a/b=0, rd_valid_a/b=0, pipeline and
//    valid shift registers cleared, collision=0. RAM contents are NOT reset or cleared.
//  - Read: rd_en at cycle T -> rd_data/rd_valid at T+READ_LATENCY. Fully pipelined, one read per port
//    per cycle, no stalls. rd_data holds its last value while no new read completes (registers enabled
//    by the valid pipeline). rd_valid stays 0 in all other cycles.
//  - Write: lanes with wr_en & wr_be[i] update at posedge T. Other lanes keep their old contents.
//  - Same port, same cycle, rd_en & wr_en (same address by construction):
//      READ_FIRST  -> returns the pre-write word.
//      WRITE_FIRST -> returns the merged word: new data on enabled lanes, old data elsewhere.
//  - Cross port, same address, same cycle:
//      A writes, B reads (or vice versa) -> the reader gets the pre-write word (old data).
//      Both write -> port A wins on every lane where both are enabled. Lanes enabled on only one port
//      take that port's data.
//  - rst asserted mid-read: in-flight reads are dropped and no rd_valid is produced for them. A write
//    in the reset cycle is not guaranteed.
//  - READ_LATENCY outside {1,2} or DATA_WIDTH % BYTE_WIDTH != 0: elaboration error ($error in an
//    initial/generate check).
// CONFIGURATION
//  BRAM_COLLISION_DETECT_EN defined:
//    collision is a registered 1-cycle pulse at T+1 when addr_a==addr_b at T and at least one port
//    writes while the other reads or writes. Same-port read+write does not count.
//    Reset value is 0. Purely observational; data behaviour is unchanged.
//  BRAM_COLLISION_DETECT_EN not defined:
//    the collision port and its comparator logic are absent. Port list ends at rd_valid_b.
// TESTING
//  1 Latency: READ_LATENCY=2. Write A addr 5 = 32'hDEADBEEF, be=4'hF. Read A addr 5 at T
//    -> rd_valid_a=1 and rd_data_a=32'hDEADBEEF at T+2 only.
//  2 Byte lanes: init addr 9 = 32'h11223344. Write B 32'hAABBCCDD with be=4'b0101
//    -> subsequent read = 32'h11BB33DD.
//  3 Read mode: addr 3 = 32'h0. Same cycle wr_en_a+rd_en_a addr 3, data 32'h5
//    -> READ_FIRST returns 0; WRITE_FIRST returns 5; both have word=5 afterwards.
//  4 Cross-port: A writes 32'h1 and B writes 32'h2 to addr 7, be=F both -> readback = 32'h1.
//    A writes addr 8 while B reads addr 8 -> B gets the old value. With BRAM_COLLISION_DETECT_EN,
//    collision pulses one cycle after each case.
//  5 Reset mid-flight: READ_LATENCY=2, rd_en_b at T, rst pulse at T+1
//    -> rd_valid_b stays 0 and rd_data_b=0. RAM contents written before reset are still readable.
//  6 Throughput: back-to-back reads on both ports, addrs 0..15
//    -> 16 consecutive rd_valid pulses per port, data in address order.

Source files
------------

// File: rtl/block_ram_dual_port_pipelined.sv
// True dual-port block RAM with per-byte write enables, read latency of 1 or 2
// cycles and a read-valid strobe per port.
// Same-port read-during-write returns either the old word (READ_FIRST) or the
// merged word (WRITE_FIRST). A cross-port reader always sees the old word.
// When both ports write the same lane of one address, port A wins.
// Optional feature: define BRAM_COLLISION_DETECT_EN to add the registered
// `collision` output. Without it, the port list ends at rd_valid_b.
// Handshake: rd_en_x in cycle T produces a one-cycle rd_valid_x pulse in cycle
// T+READ_LATENCY, with rd_data_x qualified by it. rd_data_x holds its value
// until the next read completes. There is no backpressure, so every request
// is accepted.
module block_ram_dual_port_pipelined #(
  parameter int    DATA_WIDTH   = 32,
  parameter int    BYTE_WIDTH   = 8,
  parameter int    DEPTH        = 2**16,
  parameter int    READ_LATENCY = 1,
  parameter string RD_MODE      = "READ_FIRST",
  parameter string RAM_STYLE    = "auto"
) (
  input  logic                             clk,
  input  logic                             rst,
  input  logic [$clog2(DEPTH)-1:0]         addr_a,
  input  logic [$clog2(DEPTH)-1:0]         addr_b,
  input  logic [DATA_WIDTH-1:0]            wr_data_a,
  input  logic [DATA_WIDTH-1:0]            wr_data_b,
  input  logic [DATA_WIDTH/BYTE_WIDTH-1:0] wr_be_a,
  input  logic [DATA_WIDTH/BYTE_WIDTH-1:0] wr_be_b,
  input  logic                             wr_en_a,
  input  logic                             wr_en_b,
  input  logic                             rd_en_a,
  input  logic                             rd_en_b,
  output logic [DATA_WIDTH-1:0]            rd_data_a,
  output logic [DATA_WIDTH-1:0]            rd_data_b,
  output logic                             rd_valid_a,
  output logic                             rd_valid_b
`ifdef BRAM_COLLISION_DETECT_EN
  ,
  output logic                             collision
`endif
);

  localparam int NUM_LANES   = DATA_WIDTH / BYTE_WIDTH;
  localparam bit WRITE_FIRST = (RD_MODE == "WRITE_FIRST");

  // Reject unsupported configurations at elaboration time.
  if (READ_LATENCY != 1 && READ_LATENCY != 2) begin : g_bad_latency
    $error("block_ram_dual_port_pipelined: READ_LATENCY must be 1 or 2");
  end
  if (DATA_WIDTH % BYTE_WIDTH != 0) begin : g_bad_width
    $error("block_ram_dual_port_pipelined: DATA_WIDTH must be a multiple of BYTE_WIDTH");
  end
  if (RD_MODE != "READ_FIRST" && RD_MODE != "WRITE_FIRST") begin : g_bad_mode
    $error("block_ram_dual_port_pipelined: RD_MODE must be READ_FIRST or WRITE_FIRST");
  end
  if (RAM_STYLE == "") begin : g_bad_style
    $error("block_ram_dual_port_pipelined: RAM_STYLE must not be empty");
  end

  (* ram_style = RAM_STYLE *) logic [DATA_WIDTH-1:0] mem [DEPTH];

  logic [DATA_WIDTH-1:0] rd_word_a;
  logic [DATA_WIDTH-1:0] rd_word_b;
  logic [DATA_WIDTH-1:0] s1_data_a;
  logic [DATA_WIDTH-1:0] s1_data_b;
  logic                  s1_valid_a;
  logic                  s1_valid_b;

  // Overlays the enabled lanes of new_word onto old_word.
  function automatic logic [DATA_WIDTH-1:0] merge_lanes(
    input logic [DATA_WIDTH-1:0] old_word,
    input logic [DATA_WIDTH-1:0] new_word,
    input logic [NUM_LANES-1:0]  lane_en
  );
    logic [DATA_WIDTH-1:0] res;
    res = old_word;
    for (int i = 0; i < NUM_LANES; i++) begin
      if (lane_en[i]) res[i*BYTE_WIDTH +: BYTE_WIDTH] = new_word[i*BYTE_WIDTH +: BYTE_WIDTH];
    end
    return res;
  endfunction

  // Array write. Port B is applied first so that port A overrides it on
  // shared lanes. The contents are never reset.
  always_ff @(posedge clk) begin
    for (int i = 0; i < NUM_LANES; i++) begin
      if (wr_en_b && wr_be_b[i]) mem[addr_b][i*BYTE_WIDTH +: BYTE_WIDTH] <= wr_data_b[i*BYTE_WIDTH +: BYTE_WIDTH];
      if (wr_en_a && wr_be_a[i]) mem[addr_a][i*BYTE_WIDTH +: BYTE_WIDTH] <= wr_data_a[i*BYTE_WIDTH +: BYTE_WIDTH];
    end
  end

  // Word presented to the read register. A cross-port write is never visible
  // here; a same-port write is visible only in WRITE_FIRST mode.
  always_comb begin
    rd_word_a = mem[addr_a];
    rd_word_b = mem[addr_b];
    if (WRITE_FIRST && wr_en_a) rd_word_a = merge_lanes(mem[addr_a], wr_data_a, wr_be_a);
    if (WRITE_FIRST && wr_en_b) rd_word_b = merge_lanes(mem[addr_b], wr_data_b, wr_be_b);
  end

  // First read stage: array read register plus the valid bit. The data
  // register loads only on a read.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s1_valid_a <= 1'b0;
      s1_valid_b <= 1'b0;
      s1_data_a  <= '0;
      s1_data_b  <= '0;
    end else begin
      s1_valid_a <= rd_en_a;
      s1_valid_b <= rd_en_b;
      if (rd_en_a) s1_data_a <= rd_word_a;
      if (rd_en_b) s1_data_b <= rd_word_b;
    end
  end

  if (READ_LATENCY == 2) begin : g_lat2
    logic [DATA_WIDTH-1:0] s2_data_a;
    logic [DATA_WIDTH-1:0] s2_data_b;
    logic                  s2_valid_a;
    logic                  s2_valid_b;

    // Output register stage. It advances only when stage 1 holds a valid read.
    always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
        s2_valid_a <= 1'b0;
        s2_valid_b <= 1'b0;
        s2_data_a  <= '0;
        s2_data_b  <= '0;
      end else begin
        s2_valid_a <= s1_valid_a;
        s2_valid_b <= s1_valid_b;
        if (s1_valid_a) s2_data_a <= s1_data_a;
        if (s1_valid_b) s2_data_b <= s1_data_b;
      end
    end

    assign rd_data_a  = s2_data_a;
    assign rd_data_b  = s2_data_b;
    assign rd_valid_a = s2_valid_a;
    assign rd_valid_b = s2_valid_b;
  end else begin : g_lat1
    assign rd_data_a  = s1_data_a;
    assign rd_data_b  = s1_data_b;
    assign rd_valid_a = s1_valid_a;
    assign rd_valid_b = s1_valid_b;
  end

`ifdef BRAM_COLLISION_DETECT_EN
  logic coll_now;
  assign coll_now = (addr_a == addr_b) &&
                    ((wr_en_a && (rd_en_b || wr_en_b)) || (wr_en_b && rd_en_a));

  // Registered collision pulse for the cycle after a cross-port address clash.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) collision <= 1'b0;
    else     collision <= coll_now;
  end
`endif

endmodule

// File: tb/tb_block_ram_dual_port_pipelined.sv
// Bench for block_ram_dual_port_pipelined. Both instances receive identical
// stimulus:
//   dut_rf: READ_LATENCY=2, READ_FIRST
//   dut_wf: READ_LATENCY=1, WRITE_FIRST
// Reads push their expected word and arrival cycle to per-instance, per-port
// queues. Negedge monitors pop and compare these entries.
module tb_block_ram_dual_port_pipelined;

  logic        clk;
  logic        rst;
  logic [7:0]  addr_a, addr_b;
  logic [31:0] wr_data_a, wr_data_b;
  logic [3:0]  wr_be_a, wr_be_b;
  logic        wr_en_a, wr_en_b, rd_en_a, rd_en_b;
  logic [31:0] rf_rd_data_a, rf_rd_data_b, wf_rd_data_a, wf_rd_data_b;
  logic        rf_rd_valid_a, rf_rd_valid_b, wf_rd_valid_a, wf_rd_valid_b;
`ifdef BRAM_COLLISION_DETECT_EN
  logic        rf_collision, wf_collision;
`endif

  int compared   = 0;
  int mismatched = 0;
  int cyc        = 0;

  logic [31:0] model [256];
  logic [31:0] exp_rf_a_q[$], exp_rf_b_q[$], exp_wf_a_q[$], exp_wf_b_q[$];
  int          cyc_rf_a_q[$], cyc_rf_b_q[$], cyc_wf_a_q[$], cyc_wf_b_q[$];

  block_ram_dual_port_pipelined #(
    .DATA_WIDTH(32), .BYTE_WIDTH(8), .DEPTH(256), .READ_LATENCY(2), .RD_MODE("READ_FIRST")
  ) dut_rf (
    .clk(clk), .rst(rst), .addr_a(addr_a), .addr_b(addr_b),
    .wr_data_a(wr_data_a), .wr_data_b(wr_data_b), .wr_be_a(wr_be_a), .wr_be_b(wr_be_b),
    .wr_en_a(wr_en_a), .wr_en_b(wr_en_b), .rd_en_a(rd_en_a), .rd_en_b(rd_en_b),
    .rd_data_a(rf_rd_data_a), .rd_data_b(rf_rd_data_b),
    .rd_valid_a(rf_rd_valid_a), .rd_valid_b(rf_rd_valid_b)
`ifdef BRAM_COLLISION_DETECT_EN
    , .collision(rf_collision)
`endif
  );

  block_ram_dual_port_pipelined #(
    .DATA_WIDTH(32), .BYTE_WIDTH(8), .DEPTH(256), .READ_LATENCY(1), .RD_MODE("WRITE_FIRST")
  ) dut_wf (
    .clk(clk), .rst(rst), .addr_a(addr_a), .addr_b(addr_b),
    .wr_data_a(wr_data_a), .wr_data_b(wr_data_b), .wr_be_a(wr_be_a), .wr_be_b(wr_be_b),
    .wr_en_a(wr_en_a), .wr_en_b(wr_en_b), .rd_en_a(rd_en_a), .rd_en_b(rd_en_b),
    .rd_data_a(wf_rd_data_a), .rd_data_b(wf_rd_data_b),
    .rd_valid_a(wf_rd_valid_a), .rd_valid_b(wf_rd_valid_b)
`ifdef BRAM_COLLISION_DETECT_EN
    , .collision(wf_collision)
`endif
  );

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  function automatic logic [31:0] merge(input logic [31:0] old_w, input logic [31:0] new_w,
                                        input logic [3:0] be);
    logic [31:0] r;
    r = old_w;
    for (int i = 0; i < 4; i++) if (be[i]) r[i*8 +: 8] = new_w[i*8 +: 8];
    return r;
  endfunction

  // ---------------- driver ----------------
  // One clock of stimulus. Inputs are driven #1 after a posedge, so they are
  // captured at the next posedge and a read lands on cyc + latency.
  task automatic issue(input logic wea, input logic rea, input logic [7:0] aa,
                       input logic [31:0] da, input logic [3:0] bea,
                       input logic web, input logic reb, input logic [7:0] ab,
                       input logic [31:0] db, input logic [3:0] beb);
    logic [31:0] old_a, old_b;
    logic        exp_coll;
    wr_en_a = wea; rd_en_a = rea; addr_a = aa; wr_data_a = da; wr_be_a = bea;
    wr_en_b = web; rd_en_b = reb; addr_b = ab; wr_data_b = db; wr_be_b = beb;
    old_a = model[aa];
    old_b = model[ab];
    if (rea) begin
      exp_rf_a_q.push_back(old_a); cyc_rf_a_q.push_back(cyc + 2);
      exp_wf_a_q.push_back(wea ? merge(old_a, da, bea) : old_a); cyc_wf_a_q.push_back(cyc + 1);
    end
    if (reb) begin
      exp_rf_b_q.push_back(old_b); cyc_rf_b_q.push_back(cyc + 2);
      exp_wf_b_q.push_back(web ? merge(old_b, db, beb) : old_b); cyc_wf_b_q.push_back(cyc + 1);
    end
    if (web) model[ab] = merge(model[ab], db, beb);
    if (wea) model[aa] = merge(model[aa], da, bea);
    exp_coll = (aa == ab) && ((wea && (reb || web)) || (web && rea));
    @(posedge clk); #1;
`ifdef BRAM_COLLISION_DETECT_EN
    compared++;
    if (rf_collision !== exp_coll) begin
      mismatched++; $display("FAIL collision_rf got=%b want=%b cyc=%0d", rf_collision, exp_coll, cyc);
    end
    compared++;
    if (wf_collision !== exp_coll) begin
      mismatched++; $display("FAIL collision_wf got=%b want=%b cyc=%0d", wf_collision, exp_coll, cyc);
    end
`else
    if (exp_coll) exp_coll = 1'b0;
`endif
    wr_en_a = 1'b0; rd_en_a = 1'b0; wr_en_b = 1'b0; rd_en_b = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) begin @(posedge clk); #1; end
  endtask

  // Waits a bounded number of cycles for every outstanding read to complete.
  task automatic drain(input string tag);
    int n;
    int pend;
    n = 0;
    pend = exp_rf_a_q.size() + exp_rf_b_q.size() + exp_wf_a_q.size() + exp_wf_b_q.size();
    while (pend != 0 && n < 10) begin
      @(posedge clk); #1; n++;
      pend = exp_rf_a_q.size() + exp_rf_b_q.size() + exp_wf_a_q.size() + exp_wf_b_q.size();
    end
    compared++;
    if (pend != 0) begin
      mismatched++;
      $display("FAIL drain_%s pending_reads=%0d want 0", tag, pend);
      exp_rf_a_q.delete(); exp_rf_b_q.delete(); exp_wf_a_q.delete(); exp_wf_b_q.delete();
      cyc_rf_a_q.delete(); cyc_rf_b_q.delete(); cyc_wf_a_q.delete(); cyc_wf_b_q.delete();
    end
  endtask

  // ---------------- scoreboard monitors ----------------
  always @(negedge clk) begin : mon_rf_a
    logic [31:0] e; int c;
    if (!rst && rf_rd_valid_a) begin
      compared++;
      if (exp_rf_a_q.size() == 0) begin
        mismatched++; $display("FAIL sb_rf_a unexpected valid data=%h cyc=%0d want no valid", rf_rd_data_a, cyc);
      end else begin
        e = exp_rf_a_q.pop_front(); c = cyc_rf_a_q.pop_front();
        if (rf_rd_data_a !== e || cyc != c) begin
          mismatched++; $display("FAIL sb_rf_a got=%h@%0d want=%h@%0d", rf_rd_data_a, cyc, e, c);
        end
      end
    end
  end

  always @(negedge clk) begin : mon_rf_b
    logic [31:0] e; int c;
    if (!rst && rf_rd_valid_b) begin
      compared++;
      if (exp_rf_b_q.size() == 0) begin
        mismatched++; $display("FAIL sb_rf_b unexpected valid data=%h cyc=%0d want no valid", rf_rd_data_b, cyc);
      end else begin
        e = exp_rf_b_q.pop_front(); c = cyc_rf_b_q.pop_front();
        if (rf_rd_data_b !== e || cyc != c) begin
          mismatched++; $display("FAIL sb_rf_b got=%h@%0d want=%h@%0d", rf_rd_data_b, cyc, e, c);
        end
      end
    end
  end

  always @(negedge clk) begin : mon_wf_a
    logic [31:0] e; int c;
    if (!rst && wf_rd_valid_a) begin
      compared++;
      if (exp_wf_a_q.size() == 0) begin
        mismatched++; $display("FAIL sb_wf_a unexpected valid data=%h cyc=%0d want no valid", wf_rd_data_a, cyc);
      end else begin
        e = exp_wf_a_q.pop_front(); c = cyc_wf_a_q.pop_front();
        if (wf_rd_data_a !== e || cyc != c) begin
          mismatched++; $display("FAIL sb_wf_a got=%h@%0d want=%h@%0d", wf_rd_data_a, cyc, e, c);
        end
      end
    end
  end

  always @(negedge clk) begin : mon_wf_b
    logic [31:0] e; int c;
    if (!rst && wf_rd_valid_b) begin
      compared++;
      if (exp_wf_b_q.size() == 0) begin
        mismatched++; $display("FAIL sb_wf_b unexpected valid data=%h cyc=%0d want no valid", wf_rd_data_b, cyc);
      end else begin
        e = exp_wf_b_q.pop_front(); c = cyc_wf_b_q.pop_front();
        if (wf_rd_data_b !== e || cyc != c) begin
          mismatched++; $display("FAIL sb_wf_b got=%h@%0d want=%h@%0d", wf_rd_data_b, cyc, e, c);
        end
      end
    end
  end

  // ---------------- tests ----------------
  task automatic test_reset;
    rst = 1'b1;
    wr_en_a = 0; rd_en_a = 0; wr_en_b = 0; rd_en_b = 0;
    addr_a = 0; addr_b = 0; wr_data_a = 0; wr_data_b = 0; wr_be_a = 0; wr_be_b = 0;
    repeat (3) @(posedge clk);
    #1;
    compared++; if (rf_rd_data_a !== 32'h0) begin mismatched++; $display("FAIL reset_rf_data_a got=%h want=0", rf_rd_data_a); end
    compared++; if (rf_rd_data_b !== 32'h0) begin mismatched++; $display("FAIL reset_rf_data_b got=%h want=0", rf_rd_data_b); end
    compared++; if (wf_rd_data_a !== 32'h0) begin mismatched++; $display("FAIL reset_wf_data_a got=%h want=0", wf_rd_data_a); end
    compared++; if (wf_rd_data_b !== 32'h0) begin mismatched++; $display("FAIL reset_wf_data_b got=%h want=0", wf_rd_data_b); end
    compared++;
    if ({rf_rd_valid_a, rf_rd_valid_b, wf_rd_valid_a, wf_rd_valid_b} !== 4'b0000) begin
      mismatched++; $display("FAIL reset_valids got=%b want=0000",
                             {rf_rd_valid_a, rf_rd_valid_b, wf_rd_valid_a, wf_rd_valid_b});
    end
`ifdef BRAM_COLLISION_DETECT_EN
    compared++;
    if ({rf_collision, wf_collision} !== 2'b00) begin
      mismatched++; $display("FAIL reset_collision got=%b want=00", {rf_collision, wf_collision});
    end
`endif
    rst = 1'b0;
    idle(1);
  endtask

  task automatic test_latency;
    issue(1, 0, 8'd5, 32'hDEADBEEF, 4'hF, 0, 0, 8'd0, 32'h0, 4'h0);
    issue(0, 1, 8'd5, 32'h0, 4'h0, 0, 0, 8'd0, 32'h0, 4'h0);
    compared++; if (rf_rd_valid_a !== 1'b0) begin mismatched++; $display("FAIL lat_rf_t1 valid got=%b want=0", rf_rd_valid_a); end
    compared++;
    if (wf_rd_valid_a !== 1'b1 || wf_rd_data_a !== 32'hDEADBEEF) begin
      mismatched++; $display("FAIL lat_wf_t1 got v=%b d=%h want v=1 d=deadbeef", wf_rd_valid_a, wf_rd_data_a);
    end
    idle(1);
    compared++;
    if (rf_rd_valid_a !== 1'b1 || rf_rd_data_a !== 32'hDEADBEEF) begin
      mismatched++; $display("FAIL lat_rf_t2 got v=%b d=%h want v=1 d=deadbeef", rf_rd_valid_a, rf_rd_data_a);
    end
    idle(1);
    compared++;
    if (rf_rd_valid_a !== 1'b0 || rf_rd_data_a !== 32'hDEADBEEF) begin
      mismatched++; $display("FAIL lat_rf_t3 got v=%b d=%h want v=0 d=deadbeef (held)", rf_rd_valid_a, rf_rd_data_a);
    end
    drain("latency");
  endtask

  task automatic test_byte_lanes;
    issue(1, 0, 8'd9, 32'h11223344, 4'hF, 0, 0, 8'd0, 32'h0, 4'h0);
    issue(0, 0, 8'd0, 32'h0, 4'h0, 1, 0, 8'd9, 32'hAABBCCDD, 4'b0101);
    issue(0, 1, 8'd9, 32'h0, 4'h0, 0, 1, 8'd9, 32'h0, 4'h0);
    drain("byte_lanes");
    compared++;
    if (rf_rd_data_a !== 32'h11BB33DD || wf_rd_data_b !== 32'h11BB33DD) begin
      mismatched++; $display("FAIL byte_lanes got rf=%h wf=%h want 11bb33dd", rf_rd_data_a, wf_rd_data_b);
    end
  endtask

  task automatic test_read_mode;
    issue(1, 0, 8'd3, 32'h0, 4'hF, 0, 0, 8'd0, 32'h0, 4'h0);
    issue(1, 1, 8'd3, 32'h5, 4'hF, 0, 0, 8'd0, 32'h0, 4'h0);
    compared++;
    if (wf_rd_data_a !== 32'h5) begin mismatched++; $display("FAIL rmode_wf got=%h want=5", wf_rd_data_a); end
    idle(1);
    compared++;
    if (rf_rd_data_a !== 32'h0) begin mismatched++; $display("FAIL rmode_rf got=%h want=0", rf_rd_data_a); end
    issue(0, 1, 8'd3, 32'h0, 4'h0, 0, 1, 8'd3, 32'h0, 4'h0);
    drain("read_mode");
  endtask

  task automatic test_cross_port;
    issue(1, 0, 8'd7, 32'h1, 4'hF, 1, 0, 8'd7, 32'h2, 4'hF);
    issue(0, 1, 8'd7, 32'h0, 4'h0, 0, 0, 8'd0, 32'h0, 4'h0);
    issue(1, 0, 8'd8, 32'h00000088, 4'hF, 0, 0, 8'd0, 32'h0, 4'h0);
    issue(1, 0, 8'd8, 32'hCAFEF00D, 4'hF, 0, 1, 8'd8, 32'h0, 4'h0);
    issue(0, 1, 8'd8, 32'h0, 4'h0, 0, 1, 8'd8, 32'h0, 4'h0);
    // Partial-lane double write: A has lanes 0-1, B has lanes 1-2; A must win lane 1.
    issue(1, 0, 8'd10, 32'h44332211, 4'b0011, 1, 0, 8'd10, 32'hDDCCBBAA, 4'b0110);
    issue(0, 1, 8'd10, 32'h0, 4'h0, 0, 1, 8'd10, 32'h0, 4'h0);
    drain("cross_port");
  endtask

  task automatic test_reset_midflight;
    issue(1, 0, 8'd20, 32'h0BADF00D, 4'hF, 0, 0, 8'd0, 32'h0, 4'h0);
    drain("pre_reset");
    addr_b = 8'd20; rd_en_b = 1'b1;
    @(posedge clk); #1;
    rd_en_b = 1'b0; rst = 1'b1;
    #1;
    compared++;
    if ({rf_rd_valid_b, wf_rd_valid_b} !== 2'b00 || rf_rd_data_b !== 32'h0 || wf_rd_data_b !== 32'h0) begin
      mismatched++; $display("FAIL midrst_in_reset got v=%b rf=%h wf=%h want v=00 d=0",
                             {rf_rd_valid_b, wf_rd_valid_b}, rf_rd_data_b, wf_rd_data_b);
    end
    @(posedge clk); #1;
    rst = 1'b0;
    for (int i = 0; i < 3; i++) begin
      compared++;
      if ({rf_rd_valid_b, wf_rd_valid_b} !== 2'b00 || rf_rd_data_b !== 32'h0 || wf_rd_data_b !== 32'h0) begin
        mismatched++; $display("FAIL midrst_after_%0d got v=%b rf=%h wf=%h want v=00 d=0",
                               i, {rf_rd_valid_b, wf_rd_valid_b}, rf_rd_data_b, wf_rd_data_b);
      end
      idle(1);
    end
    issue(0, 0, 8'd0, 32'h0, 4'h0, 0, 1, 8'd20, 32'h0, 4'h0);
    drain("post_reset");
  endtask

  task automatic test_back_to_back;
    for (int i = 0; i < 16; i++)
      issue(1, 0, 8'(i), $urandom, 4'hF, 0, 0, 8'd0, 32'h0, 4'h0);
    for (int i = 0; i < 16; i++)
      issue(0, 1, 8'(i), 32'h0, 4'h0, 0, 1, 8'(i), 32'h0, 4'h0);
    drain("back_to_back");
  endtask

  task automatic test_random;
    for (int i = 0; i < 60; i++)
      issue(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 8'($urandom_range(0, 7)),
            $urandom, 4'($urandom_range(0, 15)),
            1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 8'($urandom_range(0, 7)),
            $urandom, 4'($urandom_range(0, 15)));
    drain("random");
  endtask

  // ---------------- sequence + report ----------------
  initial begin
    for (int i = 0; i < 256; i++) model[i] = 32'h0;
    test_reset();
    test_latency();
    test_byte_lanes();
    test_read_mode();
    test_cross_port();
    test_reset_midflight();
    test_back_to_back();
    test_random();
    idle(2);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
